// File: rtl/hcp_cfg_cmd_gen.sv
// HCP configuration command generator: parses TSMP payload headers and issues
// single-cycle register write/read strobes, expanding bursts word by word.
module hcp_cfg_cmd_gen #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          iv_data,
    input  logic                 i_data_valid,
    input  logic                 i_data_last,
    output logic                 o_data_ready,
    output logic                 o_wr,
    output logic                 o_rd,
    output logic [18:0]          ov_addr,
    output logic                 o_addr_fixed,
    output logic [31:0]          ov_wdata,
    output logic                 o_cmd_err,
    output logic [ERR_CNT_W-1:0] ov_err_cnt
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_DATA  = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [18:0]          addr_reg, addr_next;
    logic                 fixed_reg, fixed_next;
    logic [10:0]          rem_reg, rem_next;
    logic                 wr_reg, wr_next;
    logic                 rd_reg, rd_next;
    logic [18:0]          strobe_addr_reg, strobe_addr_next;
    logic                 strobe_fixed_reg, strobe_fixed_next;
    logic [31:0]          wdata_reg, wdata_next;
    logic                 err_reg, err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic        accept;
    logic [1:0]  hdr_type;
    logic        hdr_fixed;
    logic [10:0] hdr_len;
    logic [18:0] hdr_addr;
    logic [18:0] addr_step;

    assign o_data_ready = (state_reg != ST_RD_ISSUE);
    assign accept       = i_data_valid & o_data_ready;
    assign hdr_type     = iv_data[31:30];
    assign hdr_fixed    = iv_data[29];
    assign hdr_len      = {1'b0, iv_data[28:19]} + 11'd1;
    assign hdr_addr     = iv_data[18:0];
    assign addr_step    = fixed_reg ? addr_reg : addr_reg + 19'd1;

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        fixed_next        = fixed_reg;
        rem_next          = rem_reg;
        wr_next           = 1'b0;
        rd_next           = 1'b0;
        strobe_addr_next  = 19'd0;
        strobe_fixed_next = 1'b0;
        wdata_next        = 32'd0;
        err_next          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    addr_next  = hdr_addr;
                    fixed_next = hdr_fixed;
                    rem_next   = hdr_len;
                    case (hdr_type)
                        2'b01: begin
                            if (i_data_last) err_next   = 1'b1;
                            else             state_next = ST_WR_DATA;
                        end
                        2'b10: begin
                            // First read goes out straight from the header so
                            // the strobe lands one cycle after acceptance.
                            rd_next           = 1'b1;
                            strobe_addr_next  = hdr_addr;
                            strobe_fixed_next = hdr_fixed;
                            addr_next         = hdr_fixed ? hdr_addr : hdr_addr + 19'd1;
                            rem_next          = hdr_len - 11'd1;
                            state_next        = ST_RD_ISSUE;
                        end
                        default: begin
                            err_next = 1'b1;
                            if (!i_data_last) state_next = ST_DRAIN;
                        end
                    endcase
                end
            end
            ST_WR_DATA: begin
                if (accept) begin
                    wr_next           = 1'b1;
                    strobe_addr_next  = addr_reg;
                    strobe_fixed_next = fixed_reg;
                    wdata_next        = iv_data;
                    addr_next         = addr_step;
                    rem_next          = rem_reg - 11'd1;
                    if (rem_reg == 11'd1) begin
                        state_next = ST_IDLE;
                    end else if (i_data_last) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                // rem_reg counts reads still to issue after the one on the wire.
                if (rem_reg != 11'd0) begin
                    rd_next           = 1'b1;
                    strobe_addr_next  = addr_reg;
                    strobe_fixed_next = fixed_reg;
                    addr_next         = addr_step;
                    rem_next          = rem_reg - 11'd1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (accept && i_data_last) state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= 19'd0;
            fixed_reg        <= 1'b0;
            rem_reg          <= 11'd0;
            wr_reg           <= 1'b0;
            rd_reg           <= 1'b0;
            strobe_addr_reg  <= 19'd0;
            strobe_fixed_reg <= 1'b0;
            wdata_reg        <= 32'd0;
            err_reg          <= 1'b0;
            err_cnt_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            fixed_reg        <= fixed_next;
            rem_reg          <= rem_next;
            wr_reg           <= wr_next;
            rd_reg           <= rd_next;
            strobe_addr_reg  <= strobe_addr_next;
            strobe_fixed_reg <= strobe_fixed_next;
            wdata_reg        <= wdata_next;
            err_reg          <= err_next;
            if (err_next && (err_cnt_reg != {ERR_CNT_W{1'b1}}))
                err_cnt_reg <= err_cnt_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_wr         = wr_reg;
    assign o_rd         = rd_reg;
    assign ov_addr      = strobe_addr_reg;
    assign o_addr_fixed = strobe_fixed_reg;
    assign ov_wdata     = wdata_reg;
    assign o_cmd_err    = err_reg;
    assign ov_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_hcp_cfg_cmd_gen.sv
// Bench for hcp_cfg_cmd_gen: a command-level model predicts every output per
// cycle, and directed tests pin the model with hand-computed literals.
module tb_hcp_cfg_cmd_gen;

    localparam int NCYC = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = 32'd0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        ready, wr, rd, addr_fixed, cmd_err;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [15:0] err_cnt;

    hcp_cfg_cmd_gen #(.ERR_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .iv_data(data), .i_data_valid(valid),
        .i_data_last(last), .o_data_ready(ready), .o_wr(wr), .o_rd(rd),
        .ov_addr(addr), .o_addr_fixed(addr_fixed), .ov_wdata(wdata),
        .o_cmd_err(cmd_err), .ov_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs, indexed by the cycle in which they must be visible.
    bit          exp_wr[NCYC];
    bit          exp_rd[NCYC];
    bit          exp_fixed[NCYC];
    bit          exp_err[NCYC];
    bit          exp_busy[NCYC];
    bit          exp_clr[NCYC];
    logic [18:0] exp_addr[NCYC];
    logic [31:0] exp_wdata[NCYC];

    typedef struct {
        bit          is_wr;
        logic [18:0] a;
        logic [31:0] d;
        bit          f;
        int          c;
    } ev_t;
    ev_t log_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int mcnt = 0;
    int nr_cnt = 0;
    int ready_at = 0;
    int last_acc = 0;
    int m_mode = 0;   // 0 header expected, 1 collecting write data, 2 draining
    int m_rem = 0;
    int m_addr = 0;
    bit m_fixed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic set_err(input int k);
        if (k < NCYC) exp_err[k] = 1'b1;
    endtask

    // Command-level model: applies the header/burst rules to one accepted word.
    task automatic model_accept(input int c, input logic [31:0] w, input bit l);
        int len, a, k;
        bit f;
        if (m_mode == 0) begin
            len = int'(w[28:19]) + 1;
            a   = int'(w[18:0]);
            f   = w[29];
            if (w[31:30] == 2'b01) begin
                if (l) set_err(c + 1);
                else begin
                    m_mode = 1; m_rem = len; m_addr = a; m_fixed = f;
                end
            end else if (w[31:30] == 2'b10) begin
                for (int i = 0; i < len; i++) begin
                    k = c + 1 + i;
                    if (k < NCYC) begin
                        exp_rd[k]    = 1'b1;
                        exp_addr[k]  = 19'((a + (f ? 0 : i)) % 524288);
                        exp_fixed[k] = f;
                        exp_busy[k]  = 1'b1;
                    end
                end
                ready_at = c + 1 + len;
            end else begin
                set_err(c + 1);
                if (!l) m_mode = 2;
            end
        end else if (m_mode == 1) begin
            k = c + 1;
            if (k < NCYC) begin
                exp_wr[k]    = 1'b1;
                exp_addr[k]  = 19'(m_addr);
                exp_wdata[k] = w;
                exp_fixed[k] = m_fixed;
            end
            if (!m_fixed) m_addr = (m_addr + 1) % 524288;
            m_rem--;
            if (m_rem == 0) m_mode = 0;
            else if (l) begin
                set_err(c + 1);
                m_mode = 0;
            end
        end else begin
            if (l) m_mode = 0;
        end
    endtask

    task automatic send(input logic [31:0] w, input bit l);
        while (cyc < ready_at) @(negedge clk);
        valid = 1'b1; data = w; last = l;
        last_acc = cyc;
        model_accept(cyc, w, l);
        @(negedge clk);
        valid = 1'b0; data = 32'd0; last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (exp_clr[cyc]) mcnt = 0;
            if (exp_err[cyc]) mcnt++;
            chk("wr", 32'(wr), 32'(exp_wr[cyc]));
            chk("rd", 32'(rd), 32'(exp_rd[cyc]));
            chk("addr", 32'(addr), (exp_wr[cyc] || exp_rd[cyc]) ? 32'(exp_addr[cyc]) : 32'd0);
            chk("fixed", 32'(addr_fixed), 32'(exp_fixed[cyc]));
            chk("wdata", wdata, exp_wr[cyc] ? exp_wdata[cyc] : 32'd0);
            chk("cmd_err", 32'(cmd_err), 32'(exp_err[cyc]));
            chk("ready", 32'(ready), 32'(!exp_busy[cyc]));
            chk("err_cnt", 32'(err_cnt), 32'(mcnt));
            if (wr || rd) log_q.push_back('{wr, addr, wdata, addr_fixed, cyc});
            if (!ready) nr_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b, nr0, rb;
        fork
            compare_loop();
        join_none

        @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // 1: single write
        b = log_q.size();
        send(32'h4000_0004, 1'b0);
        send(32'h0000_0003, 1'b1);
        idle(3);
        chk("t1_count", 32'(log_q.size() - b), 32'd1);
        if (log_q.size() > b) begin
            chk("t1_is_wr", 32'(log_q[b].is_wr), 32'd1);
            chk("t1_addr", 32'(log_q[b].a), 32'd4);
            chk("t1_data", log_q[b].d, 32'd3);
            chk("t1_latency", 32'(log_q[b].c), 32'(last_acc + 1));
        end
        chk("t1_errcnt", 32'(err_cnt), 32'd0);

        // 2: read burst of 4
        b = log_q.size();
        nr0 = nr_cnt;
        send(32'h8018_0000, 1'b1);
        idle(8);
        chk("t2_count", 32'(log_q.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (log_q.size() > b + i) begin
                chk("t2_is_rd", 32'(log_q[b+i].is_wr), 32'd0);
                chk("t2_addr", 32'(log_q[b+i].a), 32'(i));
                chk("t2_cycle", 32'(log_q[b+i].c), 32'(last_acc + 1 + i));
            end
        end
        chk("t2_not_ready", 32'(nr_cnt - nr0), 32'd4);

        // 3: fixed-address write of 3
        b = log_q.size();
        send(32'h6010_0010, 1'b0);
        send(32'h0000_0011, 1'b0);
        send(32'h0000_0022, 1'b0);
        send(32'h0000_0033, 1'b1);
        idle(3);
        chk("t3_count", 32'(log_q.size() - b), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (log_q.size() > b + i) begin
                chk("t3_addr", 32'(log_q[b+i].a), 32'h10);
                chk("t3_fixed", 32'(log_q[b+i].f), 32'd1);
            end
        end

        // 4: truncated write, then a normal command
        b = log_q.size();
        send(32'h4018_0020, 1'b0);
        send(32'hAAAA_0001, 1'b0);
        send(32'hAAAA_0002, 1'b1);
        idle(3);
        chk("t4_count", 32'(log_q.size() - b), 32'd2);
        chk("t4_errcnt", 32'(err_cnt), 32'd1);
        if (log_q.size() > b + 1) chk("t4_addr2", 32'(log_q[b+1].a), 32'h21);
        send(32'h4000_0005, 1'b0);
        send(32'h0000_00C5, 1'b1);
        idle(3);
        chk("t4_next_count", 32'(log_q.size() - b), 32'd3);
        if (log_q.size() > b + 2) chk("t4_next_addr", 32'(log_q[b+2].a), 32'd5);

        // 5: illegal header, drained junk, then a normal command
        b = log_q.size();
        send(32'h0000_0000, 1'b0);
        send(32'hDEAD_0001, 1'b0);
        send(32'h4000_0001, 1'b0);
        send(32'h8000_0001, 1'b1);
        idle(3);
        chk("t5_strobes", 32'(log_q.size() - b), 32'd0);
        chk("t5_errcnt", 32'(err_cnt), 32'd2);
        send(32'h4000_0007, 1'b0);
        send(32'h0000_0077, 1'b1);
        idle(3);
        chk("t5_next_count", 32'(log_q.size() - b), 32'd1);
        if (log_q.size() > b) chk("t5_next_addr", 32'(log_q[b].a), 32'd7);

        // 6: address wrap, then reset in the middle of a 16-read burst
        b = log_q.size();
        send(32'h800F_FFFF, 1'b1);
        idle(4);
        chk("t6_count", 32'(log_q.size() - b), 32'd2);
        if (log_q.size() > b + 1) begin
            chk("t6_addr0", 32'(log_q[b].a), 32'h7FFFF);
            chk("t6_addr1", 32'(log_q[b+1].a), 32'h00000);
        end
        send(32'h8078_0100, 1'b1);
        idle(4);
        #2 rst_n = 1'b0;
        rb = log_q.size();
        m_mode = 0;
        ready_at = cyc;
        for (int k = cyc + 1; k < NCYC; k++) begin
            exp_wr[k] = 1'b0; exp_rd[k] = 1'b0; exp_err[k] = 1'b0;
            exp_busy[k] = 1'b0; exp_fixed[k] = 1'b0;
        end
        exp_clr[cyc + 1] = 1'b1;
        idle(3);
        #2 rst_n = 1'b1;
        idle(6);
        chk("t6_rst_strobes", 32'(log_q.size() - rb), 32'd0);
        chk("t6_rst_ready", 32'(ready), 32'd1);
        chk("t6_rst_errcnt", 32'(err_cnt), 32'd0);
        b = log_q.size();
        send(32'h4000_0009, 1'b0);
        send(32'h0000_0099, 1'b1);
        idle(3);
        chk("t6_post_count", 32'(log_q.size() - b), 32'd1);
        if (log_q.size() > b) chk("t6_post_data", log_q[b].d, 32'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hcp_cfg_cmd_gen.md
Name: hcp_cfg_cmd_gen

Overview:
Upstream stage of the HCP register group. It takes the 32-bit configuration payload words extracted from TSMP configuration frames and decodes command headers. It then issues single-cycle register write or read strobes (addr, addr_fixed, wdata, wr, rd) that the register group and the other HCP register slaves consume. Burst commands are expanded into per-word accesses, with auto-increment addressing unless addr_fixed is set.

Parameters:
ERR_CNT_W, 16, width of the saturating command-error counter.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; asynchronous, active-low
iv_data  input  32  payload word (header or write data)
i_data_valid  input  1  iv_data valid
i_data_last  input  1  last payload word of the current frame
o_data_ready  output  1  word accepted when i_data_valid & o_data_ready
o_wr  output  1  one-cycle write strobe
o_rd  output  1  one-cycle read strobe
ov_addr  output  19  register address for the current strobe
o_addr_fixed  output  1  fixed-address flag for the current strobe
ov_wdata  output  32  write data (0 when o_wr=0)
o_cmd_err  output  1  one-cycle pulse on a malformed command
ov_err_cnt  output  ERR_CNT_W  saturating count of o_cmd_err pulses

Behaviour:
- Header word format:
  - [31:30] type: 01 = write, 10 = read, 00/11 = illegal.
  - [29] addr_fixed.
  - [28:19] len_m1; the burst length is len_m1+1, range 1..1024.
  - [18:0] base address.
- A frame may carry several back-to-back commands. The word after the end of a command is parsed as a new header.
- Reset values: all outputs 0, except o_data_ready = 1. State = IDLE, internal counters = 0.
- o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata and o_cmd_err are registered.
- Outside a strobe cycle, ov_addr, o_addr_fixed and ov_wdata are driven to 0.
- o_wr and o_rd are never high in the same cycle.
- State IDLE (o_data_ready = 1):
  - On an accepted header, latch addr_fixed, base address and remaining = len_m1+1.
  - Type 01 without last -> WR_DATA.
  - Type 01 with last -> error pulse, stay IDLE.
  - Type 10 -> RD_ISSUE, regardless of last.
  - Illegal type without last -> error pulse, go to DRAIN.
  - Illegal type with last -> error pulse, stay IDLE.
- State WR_DATA (o_data_ready = 1):
  - Each accepted word produces o_wr = 1 the following cycle, with ov_wdata = word and ov_addr = current address.
  - The address then increments by 1 modulo 2^19; it does not increment when addr_fixed = 1. remaining decrements.
  - If remaining reaches 0 -> IDLE.
  - If i_data_last arrives with remaining > 1 -> that word is still written, o_cmd_err pulses with the write strobe, then go to IDLE.
- State RD_ISSUE (o_data_ready = 0):
  - One o_rd per cycle, starting the cycle after the header is accepted, for len_m1+1 consecutive cycles, with the same addressing rule.
  - Returns to IDLE in the cycle of the last read strobe; o_data_ready is 1 again the next cycle.
- State DRAIN (o_data_ready = 1): discard words with no strobes until an accepted word with i_data_last, then go to IDLE.
- Address wrap: base 0x7FFFF with len 2 and no fix -> addresses 0x7FFFF, then 0x00000.
- Error counter: increments on every o_cmd_err pulse and saturates at all-ones.
- Latency: accepted beat to strobe = 1 cycle, for both write data and read headers.
- Reset mid-operation: any burst is abandoned; no further strobes after reset release until a new header arrives.

Test Plan:
1. Write burst: header 0x4000_0004, i.e. write, len 1, addr 4. Then data 0x3, last.
   - One o_wr with ov_addr = 4, ov_wdata = 0x3.
   - Must arrive 1 cycle after the data beat; o_cmd_err = 0.
2. Read burst: header 0x8018_0000, i.e. read, len 4, addr 0, with last.
   - o_rd on 4 consecutive cycles, ov_addr = 0, 1, 2, 3.
   - o_data_ready = 0 for exactly 4 cycles.
3. Fixed-address write: header 0x6010_0010, i.e. write, fixed, len 3, addr 0x10. Then 3 data words.
   - Three o_wr strobes, all with ov_addr = 0x10 and o_addr_fixed = 1.
4. Truncated write: header for len 4, then only 2 words with last on the second.
   - Two o_wr strobes; o_cmd_err pulses with the second strobe; ov_err_cnt = 1.
   - A following header is parsed normally.
5. Illegal type: header 0x0000_0000 without last, then 3 junk words with last on the third.
   - One o_cmd_err; no strobes; back in IDLE afterwards.
6. Wrap and reset:
   - Read at 0x7FFFF, len 2 -> addresses 0x7FFFF then 0x00000.
   - Assert i_rst_n low mid-burst in a 16-word read -> all outputs 0 and o_data_ready = 1 after release; no further o_rd.
